// File: rtl/gticc_rxlink.sv
// Receive link layer for the 16-bit 8b/10b ICC link: K28.5 comma alignment,
// HUNT/CHECK/SYNC link tracking, payload output. Optional macro: GTICC_RXLINK_ERRCNT_EN.
module gticc_rxlink #(
  parameter int DWIDTH   = 16,
  parameter int SYNC_CNT = 4,
  parameter int ERR_MAX  = 4,
  localparam int DBYTE   = DWIDTH / 8
) (
  input  logic              rxusrclk,
  input  logic              reset,
  input  logic              rxresetdone,
  input  logic [DWIDTH-1:0] rxdata,
  input  logic [DBYTE-1:0]  rxcharisk,
  input  logic [DBYTE-1:0]  rxdisperr,
  input  logic [DBYTE-1:0]  rxnotintable,
  output logic [DWIDTH-1:0] dout,
  output logic              dout_valid,
  output logic              linkup,
  output logic              lane_off,
  output logic [15:0]       errcnt
);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    CHECK = 2'd1,
    SYNC  = 2'd2
  } state_t;

  localparam logic [7:0] COMMA    = 8'hBC;
  localparam logic [7:0] SYNC_LIM = 8'(SYNC_CNT);
  localparam logic [7:0] ERR_LIM  = 8'(ERR_MAX);

  // Two-word stage: only the upper byte of the older word is ever needed.
  logic [15:0] cur_data;
  logic [1:0]  cur_k;
  logic [1:0]  cur_err;
  logic [7:0]  prev_data;
  logic        prev_k;
  logic        prev_err;

  state_t      state_q, state_d;
  logic [7:0]  synccnt_q, synccnt_d;
  logic [7:0]  run_q, run_d;
  logic        lane_off_q, lane_off_d;
  logic        valid_d;
  logic [15:0] dout_q;
  logic        dout_valid_q;

  logic [15:0] al_data;
  logic [1:0]  al_k;
  logic [1:0]  al_err;
  logic        word_comma, word_data, word_bad;
  logic        raw0, raw1, raw_hit, raw_off;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge rxusrclk) begin
    if (reset) begin
      cur_data  <= '0;
      cur_k     <= '0;
      cur_err   <= '0;
      prev_data <= '0;
      prev_k    <= 1'b0;
      prev_err  <= 1'b0;
    end else begin
      cur_data  <= rxdata;
      cur_k     <= rxcharisk;
      cur_err   <= rxdisperr | rxnotintable;
      prev_data <= cur_data[15:8];
      prev_k    <= cur_k[1];
      prev_err  <= cur_err[1];
    end
  end

  assign al_data = lane_off_q ? {cur_data[7:0], prev_data} : cur_data;
  assign al_k    = lane_off_q ? {cur_k[0], prev_k}         : cur_k;
  assign al_err  = lane_off_q ? {cur_err[0], prev_err}     : cur_err;

  assign word_comma = (al_data[7:0] == COMMA) && (al_k == 2'b01) && (al_err == 2'b00);
  assign word_data  = (al_k == 2'b00) && (al_err == 2'b00);
  assign word_bad   = !word_comma && !word_data;

  // Hunting looks at the raw word; byte 0 wins when both bytes carry a comma.
  assign raw0    = (cur_data[7:0]  == COMMA) && cur_k[0] && !cur_err[0];
  assign raw1    = (cur_data[15:8] == COMMA) && cur_k[1] && !cur_err[1];
  assign raw_hit = raw0 || raw1;
  assign raw_off = !raw0;

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    synccnt_d  = synccnt_q;
    run_d      = run_q;
    lane_off_d = lane_off_q;
    valid_d    = 1'b0;

    if (!rxresetdone) begin
      state_d   = HUNT;
      synccnt_d = '0;
      run_d     = '0;
    end else begin
      unique case (state_q)
        HUNT: begin
          if (raw_hit) begin
            lane_off_d = raw_off;
            synccnt_d  = 8'd1;
            run_d      = '0;
            state_d    = (SYNC_LIM == 8'd1) ? SYNC : CHECK;
          end
        end
        CHECK: begin
          // A comma at the other offset means we locked onto the wrong byte.
          if (raw_hit && (raw_off != lane_off_q)) begin
            lane_off_d = raw_off;
            synccnt_d  = 8'd1;
          end else if (word_comma) begin
            synccnt_d = synccnt_q + 8'd1;
            if (synccnt_q + 8'd1 == SYNC_LIM) state_d = SYNC;
          end else if (word_bad) begin
            state_d   = HUNT;
            synccnt_d = '0;
          end
        end
        SYNC: begin
          if (word_data) begin
            valid_d = 1'b1;
            run_d   = '0;
          end else if (word_comma) begin
            run_d = '0;
          end else if (run_q + 8'd1 == ERR_LIM) begin
            state_d = HUNT;
            run_d   = '0;
          end else begin
            run_d = run_q + 8'd1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge rxusrclk) begin
    if (reset) begin
      state_q      <= HUNT;
      synccnt_q    <= '0;
      run_q        <= '0;
      lane_off_q   <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      synccnt_q    <= synccnt_d;
      run_q        <= run_d;
      lane_off_q   <= lane_off_d;
      dout_valid_q <= valid_d;
      if (valid_d) dout_q <= al_data;
    end
  end

`ifdef GTICC_RXLINK_ERRCNT_EN
  logic [15:0] errcnt_q;
  logic        err_inc;

  assign err_inc = rxresetdone && (state_q == SYNC) && word_bad;

  always_ff @(posedge rxusrclk) begin
    if (reset) begin
      errcnt_q <= '0;
    end else if (err_inc && (errcnt_q != 16'hFFFF)) begin
      errcnt_q <= errcnt_q + 16'd1;
    end
  end

  assign errcnt = errcnt_q;
`else
  assign errcnt = 16'h0000;
`endif

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign linkup     = (state_q == SYNC);
  assign lane_off   = lane_off_q;

endmodule
